// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU sharing arbiter:
// FSM state encoding and the named ALU control codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALUC_ADD     = 4'b0000;
  localparam logic [3:0] ALUC_SUB     = 4'b0100;
  localparam logic [3:0] ALUC_AND     = 4'b0001;
  localparam logic [3:0] ALUC_OR      = 4'b0101;
  localparam logic [3:0] ALUC_XOR     = 4'b0010;
  localparam logic [3:0] ALUC_LUI     = 4'b0110;
  localparam logic [3:0] ALUC_SLL     = 4'b0011;
  localparam logic [3:0] ALUC_SRL     = 4'b0111;
  localparam logic [3:0] ALUC_SRA     = 4'b1111;
  localparam logic [3:0] ALUC_ILLEGAL = 4'b1011;

  // True for the one control code the ALU leaves undefined.
  function automatic logic is_illegal(input logic [3:0] aluc);
    return aluc == ALUC_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU of sc_computer. Bit 3 of aluc is a don't-care
// for the arithmetic/logic ops and selects SRL vs SRA for the right shifts.
// Shifts move b by the full value of a; code 4'b1011 is undefined and yields 0.
module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   aluc,
  output logic [W-1:0] s,
  output logic         z
);

  // Operation decode; the zero flag is derived from whatever result is chosen.
  always_comb begin
    s = '0;
    casez (aluc)
      4'b?000: s = a + b;
      4'b?100: s = a - b;
      4'b?001: s = a & b;
      4'b?101: s = a | b;
      4'b?010: s = a ^ b;
      4'b?110: s = b << 16;
      4'b0011: s = b << a;
      4'b0111: s = b >> a;
      4'b1111: s = $signed(b) >>> a;
      default: s = '0;
    endcase
    z = (s == '0);
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between two requesters. Requests are granted round-robin,
// operands are registered, the ALU runs for one cycle, and the registered result
// is held until the owning requester accepts it. One operation per three cycles.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_aluc,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_s,
  output logic              rsp_z,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       op_count
);

  state_t          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            owner_q, owner_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [3:0]      aluc_q, aluc_d;
  logic [W-1:0]    s_q, s_d;
  logic            z_q, z_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;
  logic [15:0]     op_count_q, op_count_d;

  logic            grant;
  logic            grant_valid;
  logic            handshake;
  logic [W-1:0]    alu_s;
  logic            alu_z;

  // The ALU only ever sees the operand registers, never the live request buses.
  alu #(.W(W)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .aluc (aluc_q),
    .s    (alu_s),
    .z    (alu_z)
  );

  // Round-robin grant: first valid requester starting at rr_ptr, offered only in IDLE.
  always_comb begin
    grant       = rr_ptr_q;
    grant_valid = 1'b0;
    if (req_valid[rr_ptr_q]) begin
      grant       = rr_ptr_q;
      grant_valid = 1'b1;
    end else if (req_valid[~rr_ptr_q]) begin
      grant       = ~rr_ptr_q;
      grant_valid = 1'b1;
    end
    req_ready = '0;
    if (resetn && (state_q == IDLE) && grant_valid) begin
      req_ready[grant] = 1'b1;
    end
    handshake = resetn && (state_q == IDLE) && grant_valid;
  end

  // Sequencer next-state: capture on handshake, evaluate in EXEC, hold in RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    aluc_d      = aluc_q;
    s_d         = s_q;
    z_d         = z_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          owner_d = grant;
          a_d     = req_a[grant*W +: W];
          b_d     = req_b[grant*W +: W];
          aluc_d  = req_aluc[grant*4 +: 4];
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d                  = alu_s;
        z_d                  = alu_z;
        err_d                = is_illegal(aluc_q);
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          op_count_d  = op_count_q + 16'd1;
          rr_ptr_d    = ~owner_q;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluc_q      <= '0;
      s_q         <= '0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluc_q      <= aluc_d;
      s_q         <= s_d;
      z_q         <= z_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = s_q;
  assign rsp_z     = z_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table, hand-written corner sequences
// and a randomized run scored against a transaction-level reference model.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic        clock;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_aluc;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_s;
  logic        rsp_z;
  logic        rsp_err;
  logic        busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] s;
    logic        z;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  alu_share_arb #(.NREQ(2), .W(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_aluc  (req_aluc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_z     (rsp_z),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ALU written from the opcode table, with explicit shift saturation.
  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op[2:0])
      3'b000: return a + b;
      3'b100: return a - b;
      3'b001: return a & b;
      3'b101: return a | b;
      3'b010: return a ^ b;
      3'b110: return {b[15:0], 16'h0000};
      3'b011: begin
        if (op[3]) return 32'h0;
        if (a >= 32) return 32'h0;
        return b << a[4:0];
      end
      default: begin
        if (op[3]) begin
          if (a >= 32) return {32{b[31]}};
          return $signed(b) >>> a[4:0];
        end
        if (a >= 32) return 32'h0;
        return b >> a[4:0];
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op);
    req_valid[r]        = 1'b1;
    req_a[r*32 +: 32]   = a;
    req_b[r*32 +: 32]   = b;
    req_aluc[r*4 +: 4]  = op;
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn    = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_aluc  = '0;
    #1;
    checkOutput("reset req_ready", req_ready, 2'b00);
    checkOutput("reset rsp_valid", rsp_valid, 2'b00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset op_count", op_count, 16'h0);
    checkOutput("reset rsp_s", rsp_s, 32'h0);
    checkOutput("reset rsp_z", rsp_z, 1'b0);
    checkOutput("reset rsp_err", rsp_err, 1'b0);
    @(negedge clock);
    req_valid = 2'b00;
    resetn    = 1'b1;
    #1;
  endtask

  // One operation with rsp_ready high; checks the handshake/EXEC/RESP/IDLE cadence.
  task automatic runOne(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] es, input logic ez,
                        input logic eerr, input string tag);
    int waited;
    bit got;
    applyStimulus(r, a, b, op);
    rsp_ready = 2'b11;
    waited = 0;
    got = 0;
    #1;
    while (!got && waited < 20) begin
      if (req_ready[r]) got = 1;
      else begin
        @(negedge clock);
        #1;
        waited++;
      end
    end
    checkOutput({tag, " granted"}, got, 1);
    checkOutput({tag, " grant wait"}, waited, 0);
    @(negedge clock);
    req_valid[r] = 1'b0;
    #1;
    checkOutput({tag, " exec rsp_valid"}, rsp_valid, 2'b00);
    checkOutput({tag, " exec busy"}, busy, 1'b1);
    @(negedge clock);
    #1;
    checkOutput({tag, " rsp_valid"}, rsp_valid, 32'd1 << r);
    checkOutput({tag, " rsp_s"}, rsp_s, es);
    checkOutput({tag, " rsp_z"}, rsp_z, ez);
    checkOutput({tag, " rsp_err"}, rsp_err, eerr);
    @(negedge clock);
    #1;
    checkOutput({tag, " done rsp_valid"}, rsp_valid, 2'b00);
    checkOutput({tag, " done busy"}, busy, 1'b0);
  endtask

  // Randomized run scored by a transaction-level model of grants and responses.
  task automatic randomRun(input int cycles);
    bit          hold [2];
    logic [31:0] ha [2];
    logic [31:0] hb [2];
    logic [3:0]  hop [2];
    bit          inflight;
    int          age;
    int          owner;
    int          ptr;
    int          expCount;
    logic [31:0] opA, opB, expS;
    logic [3:0]  opC;
    logic [1:0]  expReady, expValid;
    inflight = 0; age = 0; owner = 0; ptr = 0; expCount = 0;
    opA = 0; opB = 0; opC = 0;
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0; ha[i] = 0; hb[i] = 0; hop[i] = 0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i] && ($urandom_range(0, 3) == 0)) begin
          hold[i] = 1;
          ha[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
          hb[i]   = $urandom;
          hop[i]  = 4'($urandom_range(0, 15));
        end
        req_valid[i]       = hold[i];
        req_a[i*32 +: 32]  = ha[i];
        req_b[i*32 +: 32]  = hb[i];
        req_aluc[i*4 +: 4] = hop[i];
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      if (inflight) age++;
      expReady = 2'b00;
      if (!inflight) begin
        if (hold[ptr]) expReady[ptr] = 1'b1;
        else if (hold[1-ptr]) expReady[1-ptr] = 1'b1;
      end
      expValid = (inflight && age >= 2) ? 2'(1 << owner) : 2'b00;
      checkOutput("rand req_ready", req_ready, expReady);
      checkOutput("rand rsp_valid", rsp_valid, expValid);
      checkOutput("rand busy", busy, inflight);
      checkOutput("rand op_count", op_count, expCount);
      if (expValid != 2'b00) begin
        expS = refAlu(opA, opB, opC);
        checkOutput("rand rsp_s", rsp_s, expS);
        checkOutput("rand rsp_z", rsp_z, expS == 32'h0);
        checkOutput("rand rsp_err", rsp_err, opC == 4'b1011);
      end
      if (inflight && age >= 2 && rsp_ready[owner]) begin
        inflight = 0;
        expCount = (expCount + 1) % 65536;
        ptr      = 1 - owner;
      end else if (!inflight && expReady != 2'b00) begin
        owner       = expReady[1] ? 1 : 0;
        inflight    = 1;
        age         = 0;
        opA         = ha[owner];
        opB         = hb[owner];
        opC         = hop[owner];
        hold[owner] = 0;
      end
    end
    @(negedge clock);
    req_valid = 2'b00;
  endtask

  initial begin
    int n;
    int guard;
    resetn    = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_aluc  = '0;

    vecs.push_back('{32'd5,        32'd3,        ALUC_ADD,     32'd8,        1'b0, 1'b0});
    vecs.push_back('{32'd7,        32'd7,        ALUC_SUB,     32'd0,        1'b1, 1'b0});
    vecs.push_back('{32'd0,        32'd1,        ALUC_SUB,     32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,        ALUC_ADD,     32'd0,        1'b1, 1'b0});
    vecs.push_back('{32'h0000F0F0, 32'h00000FF0, ALUC_AND,     32'h000000F0, 1'b0, 1'b0});
    vecs.push_back('{32'h000000F0, 32'h0000000F, ALUC_OR,      32'h000000FF, 1'b0, 1'b0});
    vecs.push_back('{32'h000000FF, 32'h0000000F, ALUC_XOR,     32'h000000F0, 1'b0, 1'b0});
    vecs.push_back('{32'd0,        32'h00001234, ALUC_LUI,     32'h12340000, 1'b0, 1'b0});
    vecs.push_back('{32'd4,        32'd1,        ALUC_SLL,     32'h00000010, 1'b0, 1'b0});
    vecs.push_back('{32'd32,       32'd1,        ALUC_SLL,     32'd0,        1'b1, 1'b0});
    vecs.push_back('{32'd4,        32'h80000000, ALUC_SRL,     32'h08000000, 1'b0, 1'b0});
    vecs.push_back('{32'd4,        32'hFFFF0000, ALUC_SRA,     32'hFFFFF000, 1'b0, 1'b0});
    vecs.push_back('{32'd40,       32'h80000000, ALUC_SRA,     32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'd1,        32'd2,        ALUC_ILLEGAL, 32'd0,        1'b1, 1'b1});
    vecs.push_back('{32'd2,        32'd3,        ALUC_ADD,     32'd5,        1'b0, 1'b0});

    // Directed vectors, alternating requesters, back-to-back.
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      runOne(i % 2, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].z, vecs[i].err,
             $sformatf("vec%0d", i));
    end
    checkOutput("vec op_count", op_count, vecs.size());

    // Tie arbitration: both requesters valid continuously.
    doReset();
    applyStimulus(0, 32'd1, 32'd2, ALUC_ADD);
    applyStimulus(1, 32'hF0, 32'h0F, ALUC_OR);
    rsp_ready = 2'b11;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 40) begin
      @(negedge clock);
      #1;
      guard++;
      if (rsp_valid != 2'b00) begin
        checkOutput($sformatf("tie owner%0d", n), rsp_valid, 32'd1 << (n % 2));
        checkOutput($sformatf("tie s%0d", n), rsp_s, (n % 2) ? 32'hFF : 32'd3);
        n++;
      end
    end
    checkOutput("tie completions", n, 4);
    @(negedge clock);
    #1;
    checkOutput("tie op_count", op_count, 16'd4);
    req_valid = 2'b00;

    // Backpressure on requester 1 with requester 0 waiting.
    doReset();
    applyStimulus(1, 32'd4, 32'hFFFF0000, ALUC_SRA);
    rsp_ready = 2'b01;
    #1;
    checkOutput("bp grant1", req_ready, 2'b10);
    @(negedge clock);
    req_valid[1] = 1'b0;
    applyStimulus(0, 32'd5, 32'd3, ALUC_ADD);
    guard = 0;
    #1;
    while (rsp_valid != 2'b10 && guard < 10) begin
      @(negedge clock);
      #1;
      guard++;
    end
    checkOutput("bp rsp seen", rsp_valid, 2'b10);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp held valid", rsp_valid, 2'b10);
      checkOutput("bp held s", rsp_s, 32'hFFFFF000);
      checkOutput("bp req_ready", req_ready, 2'b00);
      @(negedge clock);
      #1;
    end
    rsp_ready = 2'b11;
    @(negedge clock);
    #1;
    checkOutput("bp after rsp_valid", rsp_valid, 2'b00);
    checkOutput("bp after op_count", op_count, 16'd1);
    checkOutput("bp after grant0", req_ready, 2'b01);
    @(negedge clock);
    req_valid[0] = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("bp r0 rsp_valid", rsp_valid, 2'b01);
    checkOutput("bp r0 s", rsp_s, 32'd8);

    // Reset in the middle of RESP drops the pending response.
    doReset();
    applyStimulus(0, 32'd5, 32'd3, ALUC_ADD);
    rsp_ready = 2'b00;
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock);
    #1;
    checkOutput("mid pre rsp_valid", rsp_valid, 2'b01);
    checkOutput("mid pre s", rsp_s, 32'd8);
    resetn = 1'b0;
    #1;
    checkOutput("mid rst rsp_valid", rsp_valid, 2'b00);
    checkOutput("mid rst busy", busy, 1'b0);
    checkOutput("mid rst s", rsp_s, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      checkOutput("mid post rsp_valid", rsp_valid, 2'b00);
      checkOutput("mid post busy", busy, 1'b0);
      checkOutput("mid post op_count", op_count, 16'd0);
    end

    // Randomized traffic.
    doReset();
    randomRun(3000);

    // Counter wrap from 0xFFFF.
    doReset();
    @(negedge clock);
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    #1;
    checkOutput("wrap preload", op_count, 16'hFFFF);
    runOne(0, 32'd1, 32'd1, ALUC_ADD, 32'd2, 1'b0, 1'b0, "wrap op");
    checkOutput("wrap op_count", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
